vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Upstream timing stage for the moving-block renderer. It divides the system clock into a pixel-enable
//  and runs the 640x480@60 raster counters, producing hCount/vCount, hSync/vSync and bright.
//  It also produces a one-cycle frame_tick and a decimated move_tick. Game/position logic uses
//  move_tick as its slow update strobe, so object motion is visible and tear-free.
// PARAMETERS
//  CLK_DIV      4    system clocks per pixel (>=2; 100 MHz -> 25 MHz)
//  H_TOTAL      800  pixels per line, incl. blanking
//  H_SYNC       96   hSync low width, pixels
//  H_DISP_START 144  first visible hCount
//  H_DISP_END   784  first non-visible hCount after active video
//  V_TOTAL      525  lines per frame
//  V_SYNC       2    vSync low width, lines
//  V_DISP_START 35   first visible vCount
//  V_DISP_END   515  first non-visible vCount after active video
//  FRAME_DIV    2    frames per move_tick (>=1)
// PORTS
//  clk         in   1   system clock
//  rst         in   1   reset; one clock; reset is synchronous and active-high
//  pix_en      out  1   pixel strobe, high 1 clk in every CLK_DIV
//  hCount      out  10  horizontal position, 0..H_TOTAL-1
//  vCount      out  10  vertical position, 0..V_TOTAL-1
//  hSync       out  1   horizontal sync, active low
//  vSync       out  1   vertical sync, active low
//  bright      out  1   high inside the 640x480 visible window
//  frame_tick  out  1   1-clk pulse, first clk of each frame
//  move_tick   out  1   1-clk pulse every FRAME_DIV-th frame_tick
// BEHAVIOUR
//  - Reset (sync, rst high at posedge): div=0, hCount=0, vCount=0, frame cnt=0, frame_tick=0, move_tick=0.
//    rst asserted mid-frame has the same effect at the next edge. No partial line is completed.
//  - Divider: div counts 0..CLK_DIV-1 and wraps. pix_en = (div==CLK_DIV-1), combinational from the div register.
//    pix_en is 0 during and immediately after reset. With CLK_DIV=4, the first pix_en cycle is the 4th clock after release.
//  - Counters advance only at an edge where pix_en=1.
//    hCount: +1, wraps H_TOTAL-1 -> 0.
//    vCount: +1 only when hCount wraps; wraps V_TOTAL-1 -> 0 on the same edge.
//    Neither counter ever reaches H_TOTAL or V_TOTAL.
//  - Decodes are combinational from the registered counters, with zero latency versus hCount/vCount:
//    hSync  = ~(hCount < H_SYNC)
//    vSync  = ~(vCount < V_SYNC)
//    bright = (H_DISP_START<=hCount<H_DISP_END) && (V_DISP_START<=vCount<V_DISP_END)
//    At reset both syncs are therefore 0 (in sync pulse), and bright=0.
//  - wrap = pix_en && hCount==H_TOTAL-1 && vCount==V_TOTAL-1.
//  - frame_tick is registered and equals wrap, so it is high in exactly the one clk where (hCount,vCount) first reads (0,0).
//  - Frame counter fcnt (width clog2(FRAME_DIV)+1), updated on wrap:
//    if fcnt==FRAME_DIV-1: fcnt<=0 and move_tick<=1;
//    else: fcnt<=fcnt+1 and move_tick<=0.
//    move_tick is 0 on every non-wrap edge.
//    move_tick always coincides with a frame_tick. With FRAME_DIV=1, move_tick equals frame_tick.
//  - All outputs except pix_en/hSync/vSync/bright are flops; those four are decode of flops, glitch-free w.r.t. clk.
//  - Frame length = H_TOTAL*V_TOTAL*CLK_DIV clk = 1,680,000 at defaults.
// TESTING
//  1. rst held 3 clk, then released -> hCount=vCount=0, hSync=vSync=0, bright=0; pix_en pulses
//     at clk 4,8,12 after release; hCount=1 after the first pulse.
//  2. Run one line -> hSync low for hCount 0..95, high 96..799; hCount 799->0 with vCount 0->1;
//     line = 3200 clk.
//  3. Run to vCount=35 -> bright rises at hCount=144 and falls at 784. At vCount=514/hCount=783,
//     bright=1; at vCount=515, bright=0 for the whole line.
//  4. Run 2 full frames -> frame_tick pulses 1 clk wide, 1,680,000 clk apart, coincident with (0,0).
//     vSync low only for vCount 0..1.
//  5. FRAME_DIV=2, run 5 frames -> move_tick on frame_ticks 2 and 4 only, each 1 clk wide.
//  6. Assert rst 1 clk at hCount=400, vCount=200, fcnt=1 -> next clk all counters are 0 and no ticks.
//     Following frame_tick arrives a full frame later, and fcnt restarts from 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel-enable divider, h/v counters, sync/bright decode,
// plus a per-frame tick and a decimated move tick for slow game updates.
module vga_timing_gen #(
  parameter int CLK_DIV      = 4,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC       = 96,
  parameter int H_DISP_START = 144,
  parameter int H_DISP_END   = 784,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC       = 2,
  parameter int V_DISP_START = 35,
  parameter int V_DISP_END   = 515,
  parameter int FRAME_DIV    = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       frame_tick,
  output logic       move_tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FW = $clog2(FRAME_DIV) + 1;

  logic [DW-1:0] div;
  logic [FW-1:0] fcnt;
  logic          h_last;
  logic          v_last;
  logic          wrap;

  assign pix_en = (div == DW'(CLK_DIV - 1));
  assign h_last = (hCount == 10'(H_TOTAL - 1));
  assign v_last = (vCount == 10'(V_TOTAL - 1));
  assign wrap   = pix_en && h_last && v_last;

  // Decodes read the registered counters directly so they stay aligned with hCount/vCount.
  assign hSync  = ~(hCount < 10'(H_SYNC));
  assign vSync  = ~(vCount < 10'(V_SYNC));
  assign bright = (hCount >= 10'(H_DISP_START)) && (hCount < 10'(H_DISP_END)) &&
                  (vCount >= 10'(V_DISP_START)) && (vCount < 10'(V_DISP_END));

  always_ff @(posedge clk) begin
    if (rst) begin
      div        <= '0;
      hCount     <= '0;
      vCount     <= '0;
      fcnt       <= '0;
      frame_tick <= 1'b0;
      move_tick  <= 1'b0;
    end else begin
      div        <= pix_en ? '0 : div + DW'(1);
      frame_tick <= wrap;
      move_tick  <= 1'b0;

      if (pix_en) begin
        if (h_last) begin
          hCount <= '0;
          vCount <= v_last ? '0 : vCount + 10'd1;
        end else begin
          hCount <= hCount + 10'd1;
        end
      end

      // move_tick fires on the wrap that completes every FRAME_DIV-th frame.
      if (wrap) begin
        if (fcnt == FW'(FRAME_DIV - 1)) begin
          fcnt      <= '0;
          move_tick <= 1'b1;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end
    end
  end

endmodule
